// File: rtl/adder_bist_driver.sv
// Built-in self-test driver for the n-bit adder family.
// Two 32-bit Galois LFSRs generate the operand vectors. A golden sum travels
// alongside the adder latency, and mismatches are counted with the index of
// the first failing vector captured.
module adder_bist_driver #(
  parameter int          N           = 16,
  parameter int          NUM_VECTORS = 30000,
  parameter int          DUV_LAT     = 0,
  parameter logic [31:0] SEED_A      = 32'hACE12011,
  parameter logic [31:0] SEED_B      = 32'h5EED0BB1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         cin,
  input  logic [N-1:0] s_duv,
  input  logic         cout_duv,
  output logic [19:0]  vec_count,
  output logic [15:0]  err_count,
  output logic [19:0]  first_err_idx,
  output logic         first_err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [19:0] NUM20 = 20'(NUM_VECTORS);
  localparam int          PD    = (DUV_LAT == 0) ? 1 : DUV_LAT;

  state_t      state;
  logic [31:0] lfsr_a, lfsr_b;
  logic [31:0] next_a, next_b;
  logic [2:0]  drain_cnt;

  logic        ins_valid;
  logic [N:0]  exp_sum;
  logic        chk_valid;
  logic [N:0]  chk_sum;
  logic [19:0] chk_idx;
  logic        mismatch;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  assign next_a = lfsr_step(lfsr_a);
  assign next_b = lfsr_step(lfsr_b);

  // The vector on a/b/cin is checked only while RUN still has vectors to issue.
  // Once vec_count reaches the limit, the held last vector is not checked again.
  assign ins_valid = (state == RUN) && (vec_count != NUM20);

  // Golden result of the vector currently being driven, widened to N+1 bits.
  always_comb begin
    exp_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  end

  generate
    if (DUV_LAT == 0) begin : g_comb
      assign chk_valid = ins_valid;
      assign chk_sum   = exp_sum;
      assign chk_idx   = vec_count;
    end else begin : g_pipe
      logic        pipe_valid [PD];
      logic [N:0]  pipe_sum   [PD];
      logic [19:0] pipe_idx   [PD];

      // Delay the expected sum, valid and index to line up with the adder output.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < PD; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_sum[i]   <= '0;
            pipe_idx[i]   <= '0;
          end
        end else begin
          pipe_valid[0] <= ins_valid;
          pipe_sum[0]   <= exp_sum;
          pipe_idx[0]   <= vec_count;
          for (int unsigned i = 1; i < PD; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_sum[i]   <= pipe_sum[i-1];
            pipe_idx[i]   <= pipe_idx[i-1];
          end
        end
      end

      assign chk_valid = pipe_valid[PD-1];
      assign chk_sum   = pipe_sum[PD-1];
      assign chk_idx   = pipe_idx[PD-1];
    end
  endgenerate

  assign mismatch = chk_valid && ({cout_duv, s_duv} != chk_sum);

  // Control FSM, vector generation and error bookkeeping.
  // A start accepted in the same edge as a mismatch clears the counters,
  // because the later assignment wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      lfsr_a          <= SEED_A;
      lfsr_b          <= SEED_B;
      a               <= '0;
      b               <= '0;
      cin             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      drain_cnt       <= '0;
    end else begin
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!first_err_valid) begin
          first_err_idx   <= chk_idx;
          first_err_valid <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr_a          <= SEED_A;
            lfsr_b          <= SEED_B;
            a               <= SEED_A[N-1:0];
            b               <= SEED_B[N-1:0];
            cin             <= SEED_A[31];
            vec_count       <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            state           <= RUN;
          end
        end

        RUN: begin
          if (vec_count == NUM20) begin
            if (DUV_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 16'd0);
            end else begin
              drain_cnt <= 3'(DUV_LAT - 1);
              state     <= DRAIN;
            end
          end else begin
            vec_count <= vec_count + 20'd1;
            // After the final vector is counted, a/b/cin keep holding that vector.
            if ((vec_count + 20'd1) != NUM20) begin
              lfsr_a <= next_a;
              lfsr_b <= next_b;
              a      <= next_a[N-1:0];
              b      <= next_b[N-1:0];
              cin    <= next_a[31];
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 16'd0);
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
